// File: rtl/graph_poly_if.sv
// graph_poly_if: pixel, frame and coefficient-load bus for the polynomial plotter
interface graph_poly_if #(
  parameter int CORDW = 12,
  parameter int COEFW = 16
);
  logic                    frame;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic                    coef_we;
  logic [2:0]              coef_idx;
  logic signed [COEFW-1:0] coef_data;
  logic                    coef_pending;
  logic                    r;
  modport master (output frame, x, y, coef_we, coef_idx, coef_data, input coef_pending, r);
  modport slave (input frame, x, y, coef_we, coef_idx, coef_data, output coef_pending, r);
endinterface

// File: rtl/graph_poly.sv
// graph_poly: pipelined Horner polynomial plotter with frame-synchronous shadow coefficient bank
module graph_poly #(
  parameter int CORDW = 12,
  parameter int COEFW = 16,
  parameter int FRACW = 8,
  parameter int DEG   = 2,
  parameter int THICK = 1
) (
  input logic clk,
  input logic rst,
  graph_poly_if.slave bus
);
  localparam int ACCW = COEFW + CORDW;
  localparam int PW   = ACCW + CORDW + 1;
  localparam int DW   = ACCW + 1;
  localparam logic signed [PW-1:0]   PMAX = PW'({1'b0, {(ACCW-1){1'b1}}});
  localparam logic signed [PW-1:0]   PMIN = ~PMAX;
  localparam logic signed [ACCW-1:0] AMAX = PMAX[ACCW-1:0];
  localparam logic signed [ACCW-1:0] AMIN = PMIN[ACCW-1:0];
  localparam logic signed [DW-1:0]   TH   = DW'(THICK);
  localparam logic [2:0]             DMAX = 3'(DEG);

  logic signed [COEFW-1:0] act [0:DEG];
  logic signed [COEFW-1:0] shd [0:DEG];
  logic signed [ACCW-1:0]  acc [0:DEG];
  logic signed [CORDW-1:0] xs  [0:DEG];
  logic signed [CORDW-1:0] ys  [0:DEG];
  logic signed [ACCW-1:0]  nxt [1:DEG];
  logic signed [ACCW-1:0]  f;
  logic signed [DW-1:0]    d;
  logic                    hit, pend, r_q, wr;

  assign wr = bus.coef_we && bus.coef_idx <= DMAX;

  // Each stage forms the exact product-plus-coefficient, then clamps so overflow never wraps
  for (genvar k = 1; k <= DEG; k++) begin : g_st
    logic signed [PW-1:0] s;
    assign s = PW'(acc[k-1]) * PW'(xs[k-1]) + PW'(act[DEG-k]);
    assign nxt[k] = s > PMAX ? AMAX : s < PMIN ? AMIN : s[ACCW-1:0];
  end

  always_comb begin
    f   = acc[DEG] >>> FRACW;
    d   = DW'(f) - DW'(ys[DEG]);
    hit = d >= -TH && d <= TH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DEG; i++) begin
        act[i] <= '0;
        shd[i] <= '0;
        acc[i] <= '0;
        xs[i]  <= '0;
        ys[i]  <= '0;
      end
      pend <= 1'b0;
      r_q  <= 1'b0;
    end else begin
      // Copy reads pre-write shadow, so a coincident write waits for the next frame
      for (int i = 0; i <= DEG; i++) begin
        if (bus.frame) act[i] <= shd[i];
        if (wr && bus.coef_idx == 3'(i)) shd[i] <= bus.coef_data;
      end
      pend   <= wr | (pend & ~bus.frame);
      acc[0] <= ACCW'(act[DEG]);
      xs[0]  <= bus.x;
      ys[0]  <= bus.y;
      for (int i = 1; i <= DEG; i++) begin
        acc[i] <= nxt[i];
        xs[i]  <= xs[i-1];
        ys[i]  <= ys[i-1];
      end
      r_q <= hit;
    end
  end

  assign bus.r            = r_q;
  assign bus.coef_pending = pend;
endmodule
